seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised multi-digit, time-multiplexed 7-segment display driver. It generalises the single-digit combinational decoder to N hex digits sharing one segment bus. It adds a scan prescaler, anti-ghosting dead time, frame-synchronous value loading, per-digit blanking, decimal points and leading-zero suppression. It sits between the numeric datapath and the board's segment/anode pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8); digit 0 is the least significant, digit DIGITS-1 the most significant.
CLK_DIV, 50000, clock cycles per digit slot; must be >= DEAD+2.
DEAD, 2, cycles at the start of each slot with all anodes off.
SEG_ACTIVE_LOW, 1, 1 = SEG bits driven low to light a segment.
AN_ACTIVE_LOW, 1, 1 = AN bits driven low to enable a digit.

Ports:
CLK  in  1  system clock, rising edge.
RSTN  in  1  reset, asynchronous, active-low.
VALUE  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) belongs to digit i.
DP  in  DIGITS  decimal point enable per digit.
BLANK  in  DIGITS  1 = digit i is dark.
LZS  in  1  leading-zero suppression enable; live, not latched.
LOAD  in  1  single-cycle strobe; captures VALUE, DP and BLANK.
SEG  out  8  segments; bit0 = a … bit6 = g, bit7 = dp.
AN  out  DIGITS  digit enables.
FRAME  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Reset (RSTN low, takes effect immediately, including mid-scan):
  - slot counter cnt = 0, digit index idx = 0;
  - pending and shadow registers (value, dp, blank) = 0; pending-valid flag = 0;
  - SEG = all segments off (8'hFF when SEG_ACTIVE_LOW = 1);
  - AN = all digits off;
  - FRAME = 0.
- Scan counters:
  - cnt increments every cycle, 0..CLK_DIV-1.
  - At cnt = CLK_DIV-1: cnt goes to 0 and idx increments.
  - idx wraps from DIGITS-1 to 0. In that wrap cycle FRAME = 1 for exactly one cycle; otherwise FRAME = 0.
- Outputs are registered and updated together with cnt and idx, so they always reflect the current slot.
  - AN = onehot(idx) when cnt >= DEAD and the digit is not dark; otherwise all off.
  - SEG = hex decode of shadow nibble idx, with bit7 = shadow dp[idx], then the polarity from the parameters.
  - SEG is all off whenever AN is all off.
- Hex decode, active-high, gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Digit i is dark when either:
  - shadow blank[i] = 1, or
  - LZS = 1, i > 0, and shadow nibbles i..DIGITS-1 are all zero.
  Digit 0 is never suppressed by LZS. A dark digit's dp is not shown.
- Loading:
  - LOAD copies the inputs into the pending registers and sets pending-valid.
  - At the next frame wrap, pending is copied to shadow and pending-valid is cleared, so a frame never mixes old and new data.
  - LOAD in the same cycle as the wrap: the inputs go directly to shadow and pending-valid is cleared.
  - Repeated LOADs within one frame: the last one wins.
- Inputs are assumed synchronous to CLK; no synchroniser is included.

Test Plan:
Settings for all scenarios: DIGITS=4, CLK_DIV=8, DEAD=2, active-low defaults.
1. Reset: hold RSTN=0 -> SEG=8'hFF, AN=4'hF, FRAME=0. Release, run 10 cycles, then pull RSTN low asynchronously between edges -> outputs return to reset values immediately and cnt/idx restart from 0.
2. LOAD VALUE=16'h1234, then wait for the next FRAME:
   - idx0 slot: AN=4'hF for 2 cycles, then AN=4'b1110 with SEG=8'h99 ('4') for 6 cycles.
   - idx3 slot: SEG=8'hF9 ('1'), AN=4'b0111.
3. Frame timing: free-run -> FRAME high exactly 1 cycle in every 32, coincident with idx returning to 0.
4. LZS=1:
   - VALUE=16'h0050 -> AN never asserted in the idx3 and idx2 slots; idx1 SEG=8'h92; idx0 SEG=8'hC0.
   - VALUE=16'h0000 -> only idx0 lit, SEG=8'hC0.
5. Mid-frame LOAD of 16'hABCD while 16'h1234 is displayed -> remaining slots of the current frame still show 1234 digits; next frame idx0 SEG=8'hA1 ('d'). Then LOAD 16'h5555 on the wrap cycle -> that frame's idx0 already shows 8'h92.
6. DP=4'b0100, BLANK=4'b0010 -> idx2 SEG bit7=0; idx1 slot has AN=4'hF and SEG=8'hFF for all 8 cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver.
// Scans one digit per CLK_DIV-cycle slot and keeps every anode off for the first DEAD cycles of
// a slot so the previous digit cannot ghost. New values are held in a pending buffer and only
// reach the displayed (shadow) copy at a frame boundary, so one scan never mixes old and new data.
// All outputs are registered and are computed from the next-state counters and shadow, so they
// always describe the slot that the counters are in.
module seg7_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned DEAD           = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic                  i_lzs,
  input  logic                  i_load,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0]   CntLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]   DeadCnt = CntW'(DEAD);
  localparam logic [IdxW-1:0]   IdxLast = IdxW'(DIGITS - 1);
  localparam logic [7:0]        SegOff  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AnOff   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Hex nibble to active-high segments, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [CntW-1:0]     r_cnt;
  logic [IdxW-1:0]     r_idx;

  // Pending (written by LOAD) and shadow (displayed) copies of the inputs
  logic [4*DIGITS-1:0] r_pend_value;
  logic [DIGITS-1:0]   r_pend_dp;
  logic [DIGITS-1:0]   r_pend_blank;
  logic                r_pend_vld;
  logic [4*DIGITS-1:0] r_sh_value;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [DIGITS-1:0]   r_sh_blank;

  // Registered outputs
  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame;

  // Next-state wires
  logic                w_slot_end;
  logic                w_wrap;
  logic [CntW-1:0]     w_cnt_d;
  logic [IdxW-1:0]     w_idx_d;
  logic [4*DIGITS-1:0] w_pend_value_d;
  logic [DIGITS-1:0]   w_pend_dp_d;
  logic [DIGITS-1:0]   w_pend_blank_d;
  logic                w_pend_vld_d;
  logic [4*DIGITS-1:0] w_sh_value_d;
  logic [DIGITS-1:0]   w_sh_dp_d;
  logic [DIGITS-1:0]   w_sh_blank_d;

  // Output decode wires
  logic [DIGITS-1:0]   w_dark;
  logic                w_all_zero;
  logic [3:0]          w_nib;
  logic                w_dp_sel;
  logic                w_dark_sel;
  logic [DIGITS-1:0]   w_onehot;
  logic                w_lit;
  logic [7:0]          w_seg_on;
  logic [7:0]          w_seg_d;
  logic [DIGITS-1:0]   w_an_d;

  // Slot counter and digit index; w_wrap marks the last cycle of the last digit slot.
  always_comb begin
    w_slot_end = (r_cnt == CntLast);
    w_wrap     = w_slot_end && (r_idx == IdxLast);
    w_cnt_d    = w_slot_end ? '0 : r_cnt + 1'b1;
    w_idx_d    = r_idx;
    if (w_slot_end) begin
      w_idx_d = (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
    end
  end

  // Pending/shadow update. A LOAD in the wrap cycle bypasses pending so the new frame shows it.
  always_comb begin
    w_pend_value_d = r_pend_value;
    w_pend_dp_d    = r_pend_dp;
    w_pend_blank_d = r_pend_blank;
    w_pend_vld_d   = r_pend_vld;
    w_sh_value_d   = r_sh_value;
    w_sh_dp_d      = r_sh_dp;
    w_sh_blank_d   = r_sh_blank;
    if (w_wrap) begin
      w_pend_vld_d = 1'b0;
      if (i_load) begin
        w_sh_value_d = i_value;
        w_sh_dp_d    = i_dp;
        w_sh_blank_d = i_blank;
      end else if (r_pend_vld) begin
        w_sh_value_d = r_pend_value;
        w_sh_dp_d    = r_pend_dp;
        w_sh_blank_d = r_pend_blank;
      end
    end else if (i_load) begin
      w_pend_value_d = i_value;
      w_pend_dp_d    = i_dp;
      w_pend_blank_d = i_blank;
      w_pend_vld_d   = 1'b1;
    end
  end

  // Dark digits: explicit blank, or a leading zero (walking down from the MSD) under LZS.
  always_comb begin
    w_all_zero = 1'b1;
    w_dark     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_all_zero = w_all_zero & (w_sh_value_d[4*i +: 4] == 4'h0);
      w_dark[i]  = w_sh_blank_d[i] | (i_lzs & (i != 0) & w_all_zero);
    end
  end

  // Select the digit of the upcoming cycle and form the segment/anode patterns.
  always_comb begin
    w_nib      = 4'h0;
    w_dp_sel   = 1'b0;
    w_dark_sel = 1'b0;
    w_onehot   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_idx_d == IdxW'(i)) begin
        w_nib       = w_sh_value_d[4*i +: 4];
        w_dp_sel    = w_sh_dp_d[i];
        w_dark_sel  = w_dark[i];
        w_onehot[i] = 1'b1;
      end
    end
    w_lit    = (w_cnt_d >= DeadCnt) && !w_dark_sel;
    w_seg_on = {w_dp_sel, hex_to_seg(w_nib)};
    w_seg_d  = SegOff;
    w_an_d   = AnOff;
    if (w_lit) begin
      w_seg_d = SEG_ACTIVE_LOW ? ~w_seg_on : w_seg_on;
      w_an_d  = AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
    end
  end

  // Scan counters and load buffers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_vld   <= 1'b0;
      r_sh_value   <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '0;
    end else begin
      r_cnt        <= w_cnt_d;
      r_idx        <= w_idx_d;
      r_pend_value <= w_pend_value_d;
      r_pend_dp    <= w_pend_dp_d;
      r_pend_blank <= w_pend_blank_d;
      r_pend_vld   <= w_pend_vld_d;
      r_sh_value   <= w_sh_value_d;
      r_sh_dp      <= w_sh_dp_d;
      r_sh_blank   <= w_sh_blank_d;
    end
  end

  // Output registers; FRAME is high in the first cycle of digit 0 after a wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg   <= SegOff;
      r_an    <= AnOff;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_seg_d;
      r_an    <= w_an_d;
      r_frame <= w_wrap;
    end
  end

  assign o_seg   = r_seg;
  assign o_an    = r_an;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, CLK_DIV=8, DEAD=2, active-low).
// The driver pushes the expected outputs for every cycle; a negedge monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int DIGITS    = 4;
  localparam int CLK_DIV   = 8;
  localparam int DEAD      = 2;
  localparam int FRAME_LEN = DIGITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        lzs = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame;

  seg7_scan_driver #(
    .DIGITS(DIGITS),
    .CLK_DIV(CLK_DIV),
    .DEAD(DEAD),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_value(value),
    .i_dp(dp),
    .i_blank(blank),
    .i_lzs(lzs),
    .i_load(load),
    .o_seg(seg),
    .o_an(an),
    .o_frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   m_t;
  logic cur_lzs = 1'b0;

  // Reference state: what the current frame displays, and the last LOAD not yet shown.
  logic [15:0] disp_v, pend_v;
  logic [3:0]  disp_d, disp_b, pend_d, pend_b;
  logic        pend_vld;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected outputs in cycle t (counted from reset release) for the given frame data and LZS.
  function automatic exp_t calc(input int t, input logic [15:0] v, input logic [3:0] d,
                                input logic [3:0] b, input logic lz);
    exp_t       e;
    int         idx;
    int         c;
    logic [15:0] upper;
    logic [3:0] nib;
    logic [3:0] one;
    logic       dark;
    idx   = (t / CLK_DIV) % DIGITS;
    c     = t % CLK_DIV;
    upper = v >> (4 * idx);
    nib   = upper[3:0];
    dark  = b[idx] || (lz && idx > 0 && upper == 16'h0);
    e.t     = t;
    e.seg   = 8'hFF;
    e.an    = 4'hF;
    e.frame = (t > 0) && (t % FRAME_LEN == 0);
    if (c >= DEAD && !dark) begin
      one   = 4'b0001;
      e.an  = ~(one << idx);
      e.seg = ~{d[idx], hex_seg(nib)};
    end
    return e;
  endfunction

  // Drive cycle m_t, then push the expectation for cycle m_t+1.
  task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d,
                      input logic [3:0] b);
    int nt;
    load  = ld;
    value = v;
    dp    = d;
    blank = b;
    lzs   = cur_lzs;
    nt = m_t + 1;
    if (nt % FRAME_LEN == 0) begin
      if (ld) begin
        disp_v = v; disp_d = d; disp_b = b;
      end else if (pend_vld) begin
        disp_v = pend_v; disp_d = pend_d; disp_b = pend_b;
      end
      pend_vld = 1'b0;
    end else if (ld) begin
      pend_v = v; pend_d = d; pend_b = b; pend_vld = 1'b1;
    end
    q.push_back(calc(nt, disp_v, disp_d, disp_b, cur_lzs));
    m_t = nt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, value, dp, blank);
  endtask

  task automatic run_to_phase(input int p);
    while (m_t % FRAME_LEN != p) tick(1'b0, value, dp, blank);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (seg !== 8'hFF || an !== 4'hF || frame !== 1'b0) begin
      errors++;
      $display("FAIL %s: seg=%h an=%h frame=%b, expected seg=ff an=f frame=0",
               name, seg, an, frame);
    end
  endtask

  // Release reset just after an edge; that partial cycle is cycle 0 with counters at zero.
  task automatic do_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    disp_v = '0; disp_d = '0; disp_b = '0;
    pend_v = '0; pend_d = '0; pend_b = '0; pend_vld = 1'b0;
    m_t = 0;
    q.delete();
    q.push_back(calc(0, 16'h0, 4'h0, 4'h0, cur_lzs));
    mon_en = 1'b1;
  endtask

  // Monitor: one comparison per cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: no expectation queued, dut seg=%h an=%h frame=%b",
                 seg, an, frame);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (seg !== e.seg || an !== e.an || frame !== e.frame) begin
          errors++;
          $display("FAIL scan t=%0d: seg=%h an=%h frame=%b, expected seg=%h an=%h frame=%b",
                   e.t, seg, an, frame, e.seg, e.an, e.frame);
        end
      end
    end
  end

  initial begin
    // Reset held, then released, then asserted asynchronously mid-scan.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_hold");
    do_release();
    idle(10);
    mon_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    check_reset("async_reset_held");
    do_release();

    // Basic load of 1234, shown from the next frame.
    tick(1'b1, 16'h1234, 4'h0, 4'h0);
    idle(2 * FRAME_LEN);

    // Leading-zero suppression.
    cur_lzs = 1'b1;
    tick(1'b1, 16'h0050, 4'h0, 4'h0);
    idle(2 * FRAME_LEN);
    tick(1'b1, 16'h0000, 4'h0, 4'h0);
    idle(2 * FRAME_LEN);
    cur_lzs = 1'b0;

    // Mid-frame load, then a load in the wrap cycle.
    tick(1'b1, 16'h1234, 4'h0, 4'h0);
    idle(FRAME_LEN);
    run_to_phase(10);
    tick(1'b1, 16'hABCD, 4'h0, 4'h0);
    idle(FRAME_LEN);
    run_to_phase(FRAME_LEN - 1);
    tick(1'b1, 16'h5555, 4'h0, 4'h0);
    idle(FRAME_LEN + 4);

    // Decimal point and explicit blanking; repeated loads in one frame, last wins.
    run_to_phase(3);
    tick(1'b1, 16'h9876, 4'hF, 4'h0);
    tick(1'b1, 16'h1234, 4'b0100, 4'b0010);
    idle(2 * FRAME_LEN);

    // Randomised loads and LZS changes.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 40) == 0) cur_lzs = ~cur_lzs;
      if ($urandom_range(0, 11) == 0) begin
        logic [15:0] rv;
        rv = 16'($urandom);
        if ($urandom_range(0, 2) == 0) rv = rv & 16'h00FF;
        tick(1'b1, rv, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
      end else begin
        tick(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
      end
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
